// File: rtl/dll_lock_code_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dll_lock_code_sequencer_if                                    |
// | Brief    : DLL control/status bundle between sequencer and its host.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface dll_lock_code_sequencer_if;
    logic       ENABLE;
    logic       UPDATE_REQ;
    logic       DLL_LOCK;
    logic       DLL_DELAY_DIFF;
    logic [7:0] DLL_CODE;
    logic       DLL_POWERDOWN_N;
    logic       DLL_CODE_UPDATE;
    logic [7:0] CODE_OUT;
    logic       CODE_VALID;
    logic       CODE_CHANGED;
    logic       LOCKED;
    logic       ERROR;
    logic [1:0] RETRY_CNT;

    modport master (
        output ENABLE, UPDATE_REQ, DLL_LOCK, DLL_DELAY_DIFF, DLL_CODE,
        input  DLL_POWERDOWN_N, DLL_CODE_UPDATE, CODE_OUT, CODE_VALID,
        input  CODE_CHANGED, LOCKED, ERROR, RETRY_CNT
    );

    modport slave (
        input  ENABLE, UPDATE_REQ, DLL_LOCK, DLL_DELAY_DIFF, DLL_CODE,
        output DLL_POWERDOWN_N, DLL_CODE_UPDATE, CODE_OUT, CODE_VALID,
        output CODE_CHANGED, LOCKED, ERROR, RETRY_CNT
    );
endinterface
`default_nettype wire

// File: rtl/dll_lock_code_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dll_lock_code_sequencer                                       |
// | Brief    : DLL power/lock sequencing, lock filtering and code capture.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module dll_lock_code_sequencer #(
    parameter int PWRDN_CYCLES       = 16,
    parameter int LOCK_TIMEOUT       = 4096,
    parameter int LOCK_FILTER_CYCLES = 64,
    parameter int UPDATE_PULSE       = 4,
    parameter int CODE_SETTLE        = 2,
    parameter int UPDATE_INTERVAL    = 1024,
    parameter int MAX_RETRY          = 3
) (
    input  wire                      CLK,
    input  wire                      RESET,
    dll_lock_code_sequencer_if.slave bus
);

    localparam int c_pwr_w = $clog2(PWRDN_CYCLES + 1);
    localparam int c_tmo_w = $clog2(LOCK_TIMEOUT + 1);
    localparam int c_flt_w = $clog2(LOCK_FILTER_CYCLES + 1);
    localparam int c_pls_w = $clog2(UPDATE_PULSE + 1);
    localparam int c_stl_w = (CODE_SETTLE < 1) ? 1 : $clog2(CODE_SETTLE + 1);
    localparam int c_int_w = $clog2(UPDATE_INTERVAL + 1);

    localparam logic [c_pwr_w-1:0] c_pwr_last = c_pwr_w'(PWRDN_CYCLES - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(LOCK_TIMEOUT - 1);
    localparam logic [c_flt_w-1:0] c_flt_last = c_flt_w'(LOCK_FILTER_CYCLES - 1);
    localparam logic [c_pls_w-1:0] c_pls_last = c_pls_w'(UPDATE_PULSE - 1);
    localparam logic [c_stl_w-1:0] c_stl_last = c_stl_w'(CODE_SETTLE - 1);
    localparam logic [c_int_w-1:0] c_int_last = c_int_w'(UPDATE_INTERVAL - 1);
    localparam logic [1:0]         c_max_retry = 2'(MAX_RETRY);

    localparam logic [3:0] c_st_off       = 4'd0;
    localparam logic [3:0] c_st_pwrdn     = 4'd1;
    localparam logic [3:0] c_st_wait_lock = 4'd2;
    localparam logic [3:0] c_st_filter    = 4'd3;
    localparam logic [3:0] c_st_pulse     = 4'd4;
    localparam logic [3:0] c_st_settle    = 4'd5;
    localparam logic [3:0] c_st_capture   = 4'd6;
    localparam logic [3:0] c_st_track     = 4'd7;
    localparam logic [3:0] c_st_fault     = 4'd8;

    logic [3:0]         r_state;
    logic               r_lock_meta, r_lock_s;
    logic               r_diff_meta, r_diff_s, r_diff_d;
    logic [c_pwr_w-1:0] r_pwr_cnt;
    logic [c_tmo_w-1:0] r_tmo_cnt;
    logic [c_flt_w-1:0] r_flt_cnt;
    logic [c_pls_w-1:0] r_pls_cnt;
    logic [c_stl_w-1:0] r_stl_cnt;
    logic [c_int_w-1:0] r_int_cnt;
    logic               r_first;
    logic               r_pwrdn_n;
    logic               r_code_update;
    logic [7:0]         r_code_out;
    logic               r_code_valid;
    logic               r_code_changed;
    logic               r_locked;
    logic               r_error;
    logic [1:0]         r_retry_cnt;

    logic               w_diff_rise;
    logic               w_trigger;
    logic [1:0]         w_retry_next;

    assign w_diff_rise  = r_diff_s & ~r_diff_d;
    assign w_trigger    = (r_int_cnt == c_int_last) | bus.UPDATE_REQ | w_diff_rise;
    assign w_retry_next = (r_retry_cnt == c_max_retry) ? r_retry_cnt : r_retry_cnt + 2'd1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state        <= c_st_off;
            r_lock_meta    <= 1'b0;
            r_lock_s       <= 1'b0;
            r_diff_meta    <= 1'b0;
            r_diff_s       <= 1'b0;
            r_diff_d       <= 1'b0;
            r_pwr_cnt      <= '0;
            r_tmo_cnt      <= '0;
            r_flt_cnt      <= '0;
            r_pls_cnt      <= '0;
            r_stl_cnt      <= '0;
            r_int_cnt      <= '0;
            r_first        <= 1'b0;
            r_pwrdn_n      <= 1'b0;
            r_code_update  <= 1'b0;
            r_code_out     <= 8'h00;
            r_code_valid   <= 1'b0;
            r_code_changed <= 1'b0;
            r_locked       <= 1'b0;
            r_error        <= 1'b0;
            r_retry_cnt    <= 2'd0;
        end else begin
            r_lock_meta    <= bus.DLL_LOCK;
            r_lock_s       <= r_lock_meta;
            r_diff_meta    <= bus.DLL_DELAY_DIFF;
            r_diff_s       <= r_diff_meta;
            r_diff_d       <= r_diff_s;
            r_code_changed <= 1'b0;

            if (!bus.ENABLE) begin
                r_state       <= c_st_off;
                r_pwrdn_n     <= 1'b0;
                r_code_update <= 1'b0;
                r_locked      <= 1'b0;
                r_code_valid  <= 1'b0;
            end else begin
                case (r_state)
                    c_st_off: begin
                        r_state     <= c_st_pwrdn;
                        r_pwr_cnt   <= '0;
                        r_retry_cnt <= 2'd0;
                        r_error     <= 1'b0;
                        r_pwrdn_n   <= 1'b0;
                    end

                    c_st_pwrdn: begin
                        if (r_pwr_cnt == c_pwr_last) begin
                            r_state   <= c_st_wait_lock;
                            r_pwrdn_n <= 1'b1;
                            r_tmo_cnt <= '0;
                        end else begin
                            r_pwr_cnt <= r_pwr_cnt + 1'b1;
                        end
                    end

                    // Timeout outranks a lock seen on the same cycle.
                    c_st_wait_lock: begin
                        if (r_tmo_cnt == c_tmo_last) begin
                            r_retry_cnt <= w_retry_next;
                            r_pwrdn_n   <= 1'b0;
                            if (w_retry_next == c_max_retry) begin
                                r_state <= c_st_fault;
                                r_error <= 1'b1;
                            end else begin
                                r_state   <= c_st_pwrdn;
                                r_pwr_cnt <= '0;
                            end
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
                            if (r_lock_s) begin
                                if (LOCK_FILTER_CYCLES <= 1) begin
                                    r_state       <= c_st_pulse;
                                    r_locked      <= 1'b1;
                                    r_first       <= 1'b1;
                                    r_code_update <= 1'b1;
                                    r_pls_cnt     <= '0;
                                end else begin
                                    r_state   <= c_st_filter;
                                    r_flt_cnt <= c_flt_w'(1);
                                end
                            end
                        end
                    end

                    c_st_filter: begin
                        if (!r_lock_s) begin
                            r_state <= c_st_wait_lock;
                        end else if (r_flt_cnt == c_flt_last) begin
                            r_state       <= c_st_pulse;
                            r_locked      <= 1'b1;
                            r_first       <= 1'b1;
                            r_code_update <= 1'b1;
                            r_pls_cnt     <= '0;
                        end else begin
                            r_flt_cnt <= r_flt_cnt + 1'b1;
                        end
                    end

                    c_st_pulse, c_st_settle, c_st_capture, c_st_track: begin
                        if (!r_lock_s) begin
                            r_state       <= c_st_wait_lock;
                            r_locked      <= 1'b0;
                            r_code_valid  <= 1'b0;
                            r_code_update <= 1'b0;
                            r_tmo_cnt     <= '0;
                        end else begin
                            case (r_state)
                                c_st_pulse: begin
                                    if (r_pls_cnt == c_pls_last) begin
                                        r_code_update <= 1'b0;
                                        r_stl_cnt     <= '0;
                                        r_state       <= (CODE_SETTLE == 0) ? c_st_capture : c_st_settle;
                                    end else begin
                                        r_pls_cnt <= r_pls_cnt + 1'b1;
                                    end
                                end
                                c_st_settle: begin
                                    if (r_stl_cnt == c_stl_last) begin
                                        r_state <= c_st_capture;
                                    end else begin
                                        r_stl_cnt <= r_stl_cnt + 1'b1;
                                    end
                                end
                                c_st_capture: begin
                                    r_code_out     <= bus.DLL_CODE;
                                    r_code_valid   <= 1'b1;
                                    r_code_changed <= (bus.DLL_CODE != r_code_out) | r_first;
                                    r_first        <= 1'b0;
                                    r_int_cnt      <= '0;
                                    r_state        <= c_st_track;
                                end
                                default: begin
                                    // All triggers share one path, so coincident ones yield one update.
                                    if (w_trigger) begin
                                        r_state       <= c_st_pulse;
                                        r_code_update <= 1'b1;
                                        r_pls_cnt     <= '0;
                                    end else begin
                                        r_int_cnt <= r_int_cnt + 1'b1;
                                    end
                                end
                            endcase
                        end
                    end

                    c_st_fault: begin
                        r_pwrdn_n    <= 1'b0;
                        r_error      <= 1'b1;
                        r_locked     <= 1'b0;
                        r_code_valid <= 1'b0;
                    end

                    default: begin
                        r_state <= c_st_off;
                    end
                endcase
            end
        end
    end

    assign bus.DLL_POWERDOWN_N = r_pwrdn_n;
    assign bus.DLL_CODE_UPDATE = r_code_update;
    assign bus.CODE_OUT        = r_code_out;
    assign bus.CODE_VALID      = r_code_valid;
    assign bus.CODE_CHANGED    = r_code_changed;
    assign bus.LOCKED          = r_locked;
    assign bus.ERROR           = r_error;
    assign bus.RETRY_CNT       = r_retry_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dll_lock_code_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dll_lock_code_sequencer                                    |
// | Brief    : Directed scoreboard bench for dll_lock_code_sequencer.        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_dll_lock_code_sequencer;

    localparam int S_PDN    = 0;
    localparam int S_UPD    = 1;
    localparam int S_LOCKED = 2;
    localparam int S_VALID  = 3;
    localparam int S_CHG    = 4;
    localparam int S_ERR    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dll_lock_code_sequencer_if bus();

    dll_lock_code_sequencer #(
        .PWRDN_CYCLES       (4),
        .LOCK_TIMEOUT       (32),
        .LOCK_FILTER_CYCLES (8),
        .UPDATE_PULSE       (4),
        .CODE_SETTLE        (2),
        .UPDATE_INTERVAL    (20),
        .MAX_RETRY          (3)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_pulses = 0;

    int         q_width[$];
    logic [7:0] q_code[$];
    logic [1:0] q_retry[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            S_PDN:    return bus.DLL_POWERDOWN_N;
            S_UPD:    return bus.DLL_CODE_UPDATE;
            S_LOCKED: return bus.LOCKED;
            S_VALID:  return bus.CODE_VALID;
            S_CHG:    return bus.CODE_CHANGED;
            S_ERR:    return bus.ERROR;
            default:  return 1'b0;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Counts rising edges until the selected output is high, bounded by limit.
    task automatic wait_for(input string name, input int sel, input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!sig(sel) && n < limit);
        if (!sig(sel)) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got no event within %0d cycles, expected one", name, limit);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a pulse end, a capture or a retry step.
    int         m_width      = 0;
    logic       m_prev_upd   = 1'b0;
    logic [1:0] m_prev_retry = 2'd0;
    always @(negedge clk) begin
        if (rst) begin
            m_width    = 0;
            m_prev_upd = 1'b0;
        end else begin
            if (bus.DLL_CODE_UPDATE) begin
                if (!m_prev_upd) n_pulses++;
                m_width++;
            end else if (m_prev_upd) begin
                if (q_width.size() == 0) check("unexpected_pulse", m_width, 0);
                else                     check("pulse_width", m_width, q_width.pop_front());
                m_width = 0;
            end
            m_prev_upd = bus.DLL_CODE_UPDATE;
            if (bus.CODE_CHANGED) begin
                if (q_code.size() == 0) check("unexpected_code_changed", int'(bus.CODE_OUT), -1);
                else                    check("captured_code", int'(bus.CODE_OUT), int'(q_code.pop_front()));
            end
            if (bus.RETRY_CNT != m_prev_retry && bus.RETRY_CNT != 2'd0) begin
                if (q_retry.size() == 0) check("unexpected_retry", int'(bus.RETRY_CNT), -1);
                else                     check("retry_step", int'(bus.RETRY_CNT), int'(q_retry.pop_front()));
            end
        end
        m_prev_retry = bus.RETRY_CNT;
    end

    initial begin
        int n;
        int snap;
        bus.ENABLE         = 1'b0;
        bus.UPDATE_REQ     = 1'b0;
        bus.DLL_LOCK       = 1'b0;
        bus.DLL_DELAY_DIFF = 1'b0;
        bus.DLL_CODE       = 8'h5A;

        // Reset state
        tick(3);
        check("reset_outputs", {bus.DLL_POWERDOWN_N, bus.DLL_CODE_UPDATE, bus.CODE_OUT, bus.CODE_VALID,
                                bus.CODE_CHANGED, bus.LOCKED, bus.ERROR, bus.RETRY_CNT}, 0);
        rst = 1'b0;
        tick(1);

        // Nominal bring-up
        bus.ENABLE = 1'b1;
        wait_for("powerup", S_PDN, 20, n);
        check("powerup_latency", n, 5);
        q_width.push_back(4);
        q_code.push_back(8'h5A);
        bus.DLL_LOCK = 1'b1;
        wait_for("lock", S_LOCKED, 40, n);
        check("lock_latency", n, 10);
        wait_for("capture", S_VALID, 20, n);
        check("capture_latency", n, 7);
        check("code_out_5a", int'(bus.CODE_OUT), 'h5A);

        // Periodic update picks up a new code
        bus.DLL_CODE = 8'h5B;
        q_width.push_back(4);
        q_code.push_back(8'h5B);
        wait_for("interval", S_UPD, 40, n);
        check("update_interval", n, 20);
        wait_for("capture_5b", S_CHG, 20, n);
        check("capture_latency_5b", n, 7);

        // UPDATE_REQ coincident with interval expiry, then a request outside TRACK
        tick(19);
        bus.UPDATE_REQ = 1'b1;
        q_width.push_back(4);
        snap = n_pulses;
        tick(1);
        bus.UPDATE_REQ = 1'b0;
        tick(5);
        bus.UPDATE_REQ = 1'b1;
        tick(1);
        bus.UPDATE_REQ = 1'b0;
        tick(6);
        check("single_pulse", n_pulses - snap, 1);

        // Drift flag rise
        bus.DLL_CODE       = 8'h3C;
        bus.DLL_DELAY_DIFF = 1'b1;
        q_width.push_back(4);
        q_code.push_back(8'h3C);
        wait_for("drift", S_UPD, 10, n);
        check("drift_latency", n, 3);
        wait_for("capture_3c", S_CHG, 20, n);
        check("capture_latency_3c", n, 7);

        // Lock loss mid-pulse
        bus.UPDATE_REQ = 1'b1;
        wait_for("forced_update", S_UPD, 5, n);
        check("forced_update_latency", n, 1);
        bus.UPDATE_REQ     = 1'b0;
        bus.DLL_LOCK       = 1'b0;
        bus.DLL_DELAY_DIFF = 1'b0;
        q_width.push_back(3);
        tick(4);
        check("lockloss_flags", {bus.LOCKED, bus.CODE_VALID, bus.DLL_CODE_UPDATE, bus.DLL_POWERDOWN_N}, 1);
        check("lockloss_code_kept", int'(bus.CODE_OUT), 'h3C);

        // Glitchy relock: filter restarts on the one-cycle drop
        q_width.push_back(4);
        q_code.push_back(8'h3C);
        bus.DLL_LOCK = 1'b1;
        tick(5);
        bus.DLL_LOCK = 1'b0;
        tick(1);
        bus.DLL_LOCK = 1'b1;
        wait_for("glitch_lock", S_LOCKED, 40, n);
        check("glitch_lock_latency", n, 10);
        wait_for("relock_capture", S_CHG, 20, n);
        check("relock_capture_latency", n, 7);

        // Disable, then timeout into FAULT
        bus.ENABLE   = 1'b0;
        bus.DLL_LOCK = 1'b0;
        tick(2);
        check("disable_flags", {bus.DLL_POWERDOWN_N, bus.DLL_CODE_UPDATE, bus.LOCKED, bus.CODE_VALID}, 0);
        check("disable_code_kept", int'(bus.CODE_OUT), 'h3C);
        q_retry.push_back(2'd1);
        q_retry.push_back(2'd2);
        q_retry.push_back(2'd3);
        bus.ENABLE = 1'b1;
        wait_for("fault", S_ERR, 300, n);
        check("fault_latency", n, 109);
        check("fault_state", {bus.RETRY_CNT, bus.DLL_POWERDOWN_N, bus.LOCKED, bus.CODE_VALID}, 'b11000);
        bus.DLL_LOCK = 1'b1;
        tick(20);
        check("fault_sticky", {bus.ERROR, bus.DLL_POWERDOWN_N, bus.LOCKED}, 'b100);
        bus.ENABLE = 1'b0;
        tick(2);
        check("off_holds_error", {bus.ERROR, bus.RETRY_CNT}, 'b111);
        bus.ENABLE = 1'b1;
        tick(2);
        check("enable_clears", {bus.ERROR, bus.RETRY_CNT}, 0);

        // Relock, then reset while settling
        bus.DLL_CODE = 8'hA5;
        q_width.push_back(4);
        wait_for("relock_pulse", S_UPD, 60, n);
        check("relock_pulse_latency", n, 11);
        tick(5);
        rst = 1'b1;
        tick(1);
        check("reset_mid_settle", {bus.DLL_POWERDOWN_N, bus.DLL_CODE_UPDATE, bus.CODE_OUT, bus.CODE_VALID,
                                   bus.CODE_CHANGED, bus.LOCKED, bus.ERROR, bus.RETRY_CNT}, 0);
        bus.ENABLE = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);

        check("queues_drained", q_width.size() + q_code.size() + q_retry.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
